// File: rtl/spio_hss_multiplexer_rx_pkt_buf_pkg.sv
// Shared constants and types for the spiNNlink HSS multiplexer receive packet buffer.
//   PKT_BITS      : width of one SpiNNaker packet (header + routing key + payload)
//   RX_BUF_BITS   : log2 of the receive buffer depth
//   DROP_CNT_BITS : width of the saturating dropped-packet counter
package spio_hss_multiplexer_rx_pkt_buf_pkg;

  localparam int unsigned PKT_BITS      = 72;
  localparam int unsigned RX_BUF_BITS   = 3;
  localparam int unsigned DROP_CNT_BITS = 8;

  // One SpiNNaker packet as carried inside an HSS frame.
  typedef struct packed {
    logic [31:0] payload;
    logic [31:0] key;
    logic [7:0]  hdr;
  } pkt_t;

endpackage

// File: rtl/spio_hss_multiplexer_rx_pkt_buf_if.sv
// Bus bundle of the receive packet buffer.
//   link side   : ipkt_data/ipkt_vld (valid-only), frm_ok/frm_bad (frame CRC verdict)
//   consumer    : pkt_data/pkt_vld/pkt_rdy
//   status      : cfcf (remote may send), drop pulse, drop_cnt
// slave = buffer side, master = link/consumer side.
interface spio_hss_multiplexer_rx_pkt_buf_if #(
  parameter int unsigned CNT_BITS = spio_hss_multiplexer_rx_pkt_buf_pkg::DROP_CNT_BITS
);

  spio_hss_multiplexer_rx_pkt_buf_pkg::pkt_t ipkt_data;
  logic                                      ipkt_vld;
  logic                                      frm_ok;
  logic                                      frm_bad;
  spio_hss_multiplexer_rx_pkt_buf_pkg::pkt_t pkt_data;
  logic                                      pkt_vld;
  logic                                      pkt_rdy;
  logic                                      cfcf;
  logic                                      drop;
  logic [CNT_BITS-1:0]                       drop_cnt;

  modport slave (
    input  ipkt_data, ipkt_vld, frm_ok, frm_bad, pkt_rdy,
    output pkt_data, pkt_vld, cfcf, drop, drop_cnt
  );

  modport master (
    output ipkt_data, ipkt_vld, frm_ok, frm_bad, pkt_rdy,
    input  pkt_data, pkt_vld, cfcf, drop, drop_cnt
  );

endinterface

// File: rtl/spio_hss_multiplexer_rx_pkt_mem.sv
// Packet storage for the receive buffer: one synchronous write port, one asynchronous read port.
//   clk   : write clock
//   we    : write enable, waddr/wdata : write address/data
//   raddr : read address, rdata : combinational read data
// The array is intentionally not reset; pointers in the parent decide what is valid.
module spio_hss_multiplexer_rx_pkt_mem
  import spio_hss_multiplexer_rx_pkt_buf_pkg::*;
#(
  parameter int unsigned ADDR_BITS = RX_BUF_BITS
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  pkt_t                 wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output pkt_t                 rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  pkt_t mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read port.
  assign rdata = mem[raddr];

endmodule

// File: rtl/spio_hss_multiplexer_rx_pkt_buf.sv
// Receive-side packet buffer of the spiNNlink HSS multiplexer.
// Packets unpacked from incoming frames are stored speculatively (swp) until the frame CRC verdict:
// frm_ok commits them (cwp catches up to swp), frm_bad rewinds swp to cwp. Committed packets are
// presented on a vld/rdy port. cfcf tells the remote transmitter whether it may keep sending.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of the rx buffer interface (see _if file for signal list)
module spio_hss_multiplexer_rx_pkt_buf
  import spio_hss_multiplexer_rx_pkt_buf_pkg::*;
#(
  parameter int unsigned FIFO_BITS = RX_BUF_BITS,
  parameter int unsigned CNT_BITS  = DROP_CNT_BITS
) (
  input  logic                               clk,
  input  logic                               rst_n,
  spio_hss_multiplexer_rx_pkt_buf_if.slave   bus
);

  localparam int unsigned DEPTH    = 1 << FIFO_BITS;
  localparam int unsigned PTR_BITS = FIFO_BITS + 1;

  localparam logic [PTR_BITS-1:0] DEPTH_P = PTR_BITS'(DEPTH);
  localparam logic [PTR_BITS-1:0] HI_P    = PTR_BITS'((3 * DEPTH) / 4);
  localparam logic [PTR_BITS-1:0] LO_P    = PTR_BITS'(DEPTH / 4);

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [PTR_BITS-1:0] rdp_q, cwp_q, swp_q;
  logic [PTR_BITS-1:0] rdp_d, cwp_d, swp_d;
  logic [PTR_BITS-1:0] swp_inc;
  logic [PTR_BITS-1:0] occ_c, occ_s, occ_s_next;

  logic                cfcf_q, cfcf_d;
  logic                drop_q, drop_d;
  logic [CNT_BITS-1:0] drop_cnt_q, drop_cnt_d;

  logic                full;
  logic                wr_en;
  logic                rd_en;
  logic                pkt_vld_c;

  // Next-state logic for pointers, flow control and drop accounting.
  always_comb begin
    occ_c      = cwp_q - rdp_q;
    occ_s      = swp_q - rdp_q;
    full       = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    pkt_vld_c  = 1'b0;
    swp_inc    = swp_q;
    rdp_d      = rdp_q;
    cwp_d      = cwp_q;
    swp_d      = swp_q;
    occ_s_next = occ_s;
    cfcf_d     = cfcf_q;
    drop_d     = 1'b0;
    drop_cnt_d = drop_cnt_q;

    // Space is judged on registered occupancy only; a same-cycle read does not help.
    full      = (occ_s == DEPTH_P);
    wr_en     = bus.ipkt_vld & ~full;
    drop_d    = bus.ipkt_vld & full;
    pkt_vld_c = (occ_c != '0);
    rd_en     = pkt_vld_c & bus.pkt_rdy;

    swp_inc = swp_q + PTR_BITS'(wr_en);
    rdp_d   = rdp_q + PTR_BITS'(rd_en);

    // frm_bad dominates: rewind, including any packet written this cycle.
    if (bus.frm_bad) begin
      swp_d = cwp_q;
    end else begin
      swp_d = swp_inc;
      if (bus.frm_ok) begin
        cwp_d = swp_inc;
      end
    end

    // Hysteresis on next-cycle speculative occupancy.
    occ_s_next = swp_d - rdp_d;
    if (occ_s_next >= HI_P) begin
      cfcf_d = 1'b0;
    end else if (occ_s_next <= LO_P) begin
      cfcf_d = 1'b1;
    end

    if (drop_d && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_BITS'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdp_q      <= '0;
      cwp_q      <= '0;
      swp_q      <= '0;
      cfcf_q     <= 1'b1;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      rdp_q      <= rdp_d;
      cwp_q      <= cwp_d;
      swp_q      <= swp_d;
      cfcf_q     <= cfcf_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  spio_hss_multiplexer_rx_pkt_mem #(
    .ADDR_BITS (FIFO_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (swp_q[FIFO_BITS-1:0]),
    .wdata (bus.ipkt_data),
    .raddr (rdp_q[FIFO_BITS-1:0]),
    .rdata (bus.pkt_data)
  );

  assign bus.pkt_vld  = pkt_vld_c;
  assign bus.cfcf     = cfcf_q;
  assign bus.drop     = drop_q;
  assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_spio_hss_multiplexer_rx_pkt_buf.sv
// Testbench for spio_hss_multiplexer_rx_pkt_buf: table-driven vectors plus directed sequences for
// flow control, overflow/wrap, contention and asynchronous reset.
module tb_spio_hss_multiplexer_rx_pkt_buf;
  import spio_hss_multiplexer_rx_pkt_buf_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  spio_hss_multiplexer_rx_pkt_buf_if bif ();

  spio_hss_multiplexer_rx_pkt_buf dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [7:0] d;
    logic       ok;
    logic       bad;
    logic       rdy;
    logic       e_vld;
    logic [7:0] e_d;
    logic       e_cfcf;
  } vec_t;

  vec_t tbl [14];

  // Reference model state for the contention sequence.
  int   m_rdp, m_cwp, m_swp;
  pkt_t m_mem [8];

  function automatic pkt_t mk(input logic [7:0] b);
    pkt_t p;
    p.hdr     = b;
    p.key     = ~{4{b}};
    p.payload = {4{b}};
    return p;
  endfunction

  function automatic vec_t v(input logic vld, input logic [7:0] d, input logic ok, input logic bad,
                             input logic rdy, input logic e_vld, input logic [7:0] e_d,
                             input logic e_cfcf);
    vec_t r;
    r.vld = vld; r.d = d; r.ok = ok; r.bad = bad; r.rdy = rdy;
    r.e_vld = e_vld; r.e_d = e_d; r.e_cfcf = e_cfcf;
    return r;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkd(input string name, input pkt_t act, input pkt_t exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [7:0] d, input logic ok, input logic bad,
                       input logic rdy);
    bif.ipkt_vld  = vld;
    bif.ipkt_data = mk(d);
    bif.frm_ok    = ok;
    bif.frm_bad   = bad;
    bif.pkt_rdy   = rdy;
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_step(input logic vld, input logic [7:0] d, input logic ok, input logic bad,
                            input logic rdy);
    int swpi;
    bit wr, rd;
    wr   = vld && ((m_swp - m_rdp) < 8);
    rd   = (m_cwp != m_rdp) && rdy;
    if (wr) m_mem[m_swp % 8] = mk(d);
    swpi = m_swp + int'(wr);
    if (bad) m_swp = m_cwp;
    else begin
      m_swp = swpi;
      if (ok) m_cwp = swpi;
    end
    m_rdp = m_rdp + int'(rd);
  endtask

  initial begin
    int   ndrop;
    vec_t cs [6];

    n_chk = 0;
    n_err = 0;

    // Commit of A1..A3, discard of B1/B2, C1 alone, then frm_ok+frm_bad together with D1.
    tbl[0]  = v(1, 8'hA1, 0, 0, 1,  0, 8'h00, 1);
    tbl[1]  = v(1, 8'hA2, 0, 0, 1,  0, 8'h00, 1);
    tbl[2]  = v(1, 8'hA3, 1, 0, 1,  0, 8'h00, 1);
    tbl[3]  = v(0, 8'h00, 0, 0, 1,  1, 8'hA1, 1);
    tbl[4]  = v(0, 8'h00, 0, 0, 1,  1, 8'hA2, 1);
    tbl[5]  = v(0, 8'h00, 0, 0, 1,  1, 8'hA3, 1);
    tbl[6]  = v(1, 8'hB1, 0, 0, 1,  0, 8'h00, 1);
    tbl[7]  = v(1, 8'hB2, 0, 0, 1,  0, 8'h00, 1);
    tbl[8]  = v(0, 8'h00, 0, 1, 1,  0, 8'h00, 1);
    tbl[9]  = v(1, 8'hC1, 1, 0, 1,  0, 8'h00, 1);
    tbl[10] = v(0, 8'h00, 0, 0, 1,  1, 8'hC1, 1);
    tbl[11] = v(1, 8'hD1, 1, 1, 1,  0, 8'h00, 1);
    tbl[12] = v(0, 8'h00, 0, 0, 1,  0, 8'h00, 1);
    tbl[13] = v(0, 8'h00, 0, 0, 1,  0, 8'h00, 1);

    // Power-on reset.
    rst_n = 1'b0;
    drive(0, 8'h00, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk1("reset_pkt_vld", bif.pkt_vld, 1'b0);
    chk1("reset_cfcf", bif.cfcf, 1'b1);
    chk1("reset_drop", bif.drop, 1'b0);
    chkn("reset_drop_cnt", int'(bif.drop_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: outputs reflect all edges before this vector.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].vld, tbl[i].d, tbl[i].ok, tbl[i].bad, tbl[i].rdy);
      chk1($sformatf("vec%0d_pkt_vld", i), bif.pkt_vld, tbl[i].e_vld);
      if (tbl[i].e_vld) chkd($sformatf("vec%0d_pkt_data", i), bif.pkt_data, mk(tbl[i].e_d));
      chk1($sformatf("vec%0d_cfcf", i), bif.cfcf, tbl[i].e_cfcf);
      chk1($sformatf("vec%0d_drop", i), bif.drop, 1'b0);
      tick();
    end

    // Flow control: 6 committed packets with no reader, then drain.
    for (int i = 0; i < 6; i++) begin
      drive(1, 8'h40 + 8'(i), 1, 0, 0);
      tick();
      if (i == 4) chk1("fc_cfcf_at5", bif.cfcf, 1'b1);
      if (i == 5) chk1("fc_cfcf_at6", bif.cfcf, 1'b0);
    end
    drive(0, 8'h00, 0, 0, 1);
    for (int k = 0; k < 6; k++) begin
      chkd($sformatf("fc_data%0d", k), bif.pkt_data, mk(8'h40 + 8'(k)));
      tick();
      if (k == 2) chk1("fc_cfcf_at3", bif.cfcf, 1'b0);
      if (k == 3) chk1("fc_cfcf_at2", bif.cfcf, 1'b1);
    end
    chk1("fc_empty", bif.pkt_vld, 1'b0);

    // Overflow and pointer wrap: 10-packet frames into an 8-deep buffer.
    for (int r = 1; r <= 3; r++) begin
      ndrop = 0;
      for (int i = 0; i < 10; i++) begin
        drive(1, 8'(16 * r + i), (i == 9), 0, 0);
        chk1($sformatf("ov%0d_uncommitted%0d", r, i), bif.pkt_vld, 1'b0);
        tick();
        if (bif.drop) ndrop++;
      end
      drive(0, 8'h00, 0, 0, 1);
      chk1($sformatf("ov%0d_cfcf_full", r), bif.cfcf, 1'b0);
      for (int k = 0; k < 8; k++) begin
        chk1($sformatf("ov%0d_vld%0d", r, k), bif.pkt_vld, 1'b1);
        chkd($sformatf("ov%0d_data%0d", r, k), bif.pkt_data, mk(8'(16 * r + k)));
        tick();
        if (bif.drop) ndrop++;
      end
      chkn($sformatf("ov%0d_drop_pulses", r), ndrop, 2);
      chkn($sformatf("ov%0d_drop_cnt", r), int'(bif.drop_cnt), 2 * r);
      chk1($sformatf("ov%0d_empty", r), bif.pkt_vld, 1'b0);
      chk1($sformatf("ov%0d_cfcf_drained", r), bif.cfcf, 1'b1);
    end

    // Contention: read+write+commit together, then discard with a read in flight.
    cs[0] = v(1, 8'hE0, 0, 0, 0, 0, 0, 0);
    cs[1] = v(1, 8'hE1, 1, 0, 0, 0, 0, 0);
    cs[2] = v(1, 8'hE2, 1, 0, 1, 0, 0, 0);
    cs[3] = v(1, 8'hE3, 0, 0, 1, 0, 0, 0);
    cs[4] = v(1, 8'hE4, 0, 1, 1, 0, 0, 0);
    cs[5] = v(0, 8'h00, 0, 0, 1, 0, 0, 0);
    m_rdp = 0; m_cwp = 0; m_swp = 0;
    for (int i = 0; i < 6; i++) begin
      drive(cs[i].vld, cs[i].d, cs[i].ok, cs[i].bad, cs[i].rdy);
      chk1($sformatf("ct%0d_pkt_vld", i), bif.pkt_vld, (m_cwp != m_rdp));
      if (m_cwp != m_rdp) chkd($sformatf("ct%0d_pkt_data", i), bif.pkt_data, m_mem[m_rdp % 8]);
      model_step(cs[i].vld, cs[i].d, cs[i].ok, cs[i].bad, cs[i].rdy);
      tick();
      chkn($sformatf("ct%0d_occ_c", i), int'(dut.occ_c), m_cwp - m_rdp);
      chkn($sformatf("ct%0d_occ_s", i), int'(dut.occ_s), m_swp - m_rdp);
    end

    // Asynchronous reset mid-cycle with a nearly full buffer.
    for (int i = 0; i < 7; i++) begin
      drive(1, 8'h70 + 8'(i), 1, 0, 0);
      tick();
    end
    drive(0, 8'h00, 0, 0, 0);
    chk1("pre_rst_pkt_vld", bif.pkt_vld, 1'b1);
    chk1("pre_rst_cfcf", bif.cfcf, 1'b0);
    chkn("pre_rst_drop_cnt", int'(bif.drop_cnt), 6);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk1("async_rst_pkt_vld", bif.pkt_vld, 1'b0);
    chk1("async_rst_cfcf", bif.cfcf, 1'b1);
    chkn("async_rst_drop_cnt", int'(bif.drop_cnt), 0);
    chkn("async_rst_occ_s", int'(dut.occ_s), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 8'hF1, 1, 0, 1);
    tick();
    drive(0, 8'h00, 0, 0, 1);
    chk1("post_rst_vld", bif.pkt_vld, 1'b1);
    chkd("post_rst_data", bif.pkt_data, mk(8'hF1));
    tick();
    chk1("post_rst_empty", bif.pkt_vld, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
